rr_arbiter_16: RTL and testbench

RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

---
 rtl/rr_arbiter_16.sv | 118 +++++++++++
 tb/tb_rr_arbiter_16.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with hold-until-release grants and one dead cycle between owners.
// Define ARB_TIMEOUT_EN to force-release a grant held for TIMEOUT cycles.
module rr_arbiter_16 #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  output logic        timeout
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rr_arbiter_16: TIMEOUT out of range");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic [3:0]  ptr, ptr_nx;
  logic [15:0] grant_nx;
  logic [3:0]  idx_nx;
  logic        timeout_nx;
  logic        expire;

  // Winner search: first set request scanning upward from ptr, wrapping 15->0.
  logic [3:0]  cand;
  logic [3:0]  win_idx;
  logic        win_found;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt, cnt_nx;
  assign expire = (cnt == 16'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    grant_nx   = grant;
    idx_nx     = grant_idx;
    timeout_nx = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nx     = cnt;
`endif
    case (state)
      IDLE: begin
        grant_nx = '0;
        idx_nx   = '0;
        if (win_found) begin
          state_nx = BUSY;
          ptr_nx   = win_idx + 4'd1;
          grant_nx = 16'd1 << win_idx;
          idx_nx   = win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      BUSY: begin
        // An owner release wins over an expiring counter on the same edge.
        if (!req[grant_idx] || expire) begin
          state_nx   = IDLE;
          grant_nx   = '0;
          idx_nx     = '0;
          timeout_nx = req[grant_idx];
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_nx = cnt + 16'd1;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      grant     <= grant_nx;
      grant_idx <= idx_nx;
      timeout   <= timeout_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nx;
  end
`endif

  assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_rr_arbiter_16;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_16 #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource, whose turn is next, how long held.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_tmo;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_tmo = 0;
    end else begin
      m_tmo = 0;
      if (!m_busy) begin
        for (int k = 0; k < 16; k++) begin
          int c;
          c = (m_ptr + k) % 16;
          if (req[c]) begin
            m_busy = 1; m_owner = c; m_ptr = (c + 1) % 16; m_held = 1;
            break;
          end
        end
      end else if (!req[m_owner]) begin
        m_busy = 0;
      end else if (TMO_EN && m_held == TMO) begin
        m_busy = 0; m_tmo = 1;
      end else begin
        m_held++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 16'hFFFF;
    tick(); tick();
    checks++;
    if (grant !== 16'h0 || grant_idx !== 4'h0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%h idx=%0d valid=%b tmo=%b, want all zero", grant, grant_idx, grant_valid, timeout);
    end
    rst = 1'b0; req = '0;
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: valid=%b want 0", grant_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0010;
    tick();
    checks++;
    if (grant !== 16'h0010 || grant_idx !== 4'd4 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL single_grant: grant=%h idx=%0d valid=%b want 0010/4/1", grant, grant_idx, grant_valid);
    end
    req = 16'h0000;
    tick();
    checks++;
    if (grant !== 16'h0 || grant_valid !== 1'b0) begin
      errors++; $display("FAIL single_release: grant=%h want 0000", grant);
    end
    req = 16'h0030;  // ptr is now 5, so 5 beats 4
    tick();
    checks++;
    if (grant_idx !== 4'd5 || grant !== 16'h0020) begin
      errors++; $display("FAIL single_ptr: idx=%0d grant=%h want 5/0020", grant_idx, grant);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      int exp_idx;
      exp_idx = k % 16;
      tick();
      checks++;
      if (grant_idx !== 4'(exp_idx) || grant !== (16'd1 << exp_idx)) begin
        errors++; $display("FAIL rr_grant%0d: idx=%0d grant=%h want %0d", k, grant_idx, grant, exp_idx);
      end
      tick(); tick();
      checks++;
      if (grant_idx !== 4'(exp_idx) || grant_valid !== 1'b1) begin
        errors++; $display("FAIL rr_hold%0d: idx=%0d valid=%b want %0d/1", k, grant_idx, grant_valid, exp_idx);
      end
      req = 16'hFFFF & ~(16'd1 << exp_idx);
      tick();
      checks++;
      if (grant_valid !== 1'b0 || grant !== 16'h0) begin
        errors++; $display("FAIL rr_dead%0d: grant=%h want 0000", k, grant);
      end
      req = 16'hFFFF;
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h4000; tick();
    req = 16'h0000; tick();
    req = 16'h8001; tick();
    checks++;
    if (grant_idx !== 4'd15 || grant !== 16'h8000) begin
      errors++; $display("FAIL wrap_15: idx=%0d grant=%h want 15/8000", grant_idx, grant);
    end
    req = 16'h0001; tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_dead: valid=%b want 0", grant_valid);
    end
    tick();
    checks++;
    if (grant_idx !== 4'd0 || grant !== 16'h0001) begin
      errors++; $display("FAIL wrap_0: idx=%0d grant=%h want 0/0001", grant_idx, grant);
    end
    req = '0; tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 16'h0080; tick();
    checks++;
    if (grant_idx !== 4'd7) begin
      errors++; $display("FAIL midrst_own: idx=%0d want 7", grant_idx);
    end
    rst = 1'b1; tick();
    checks++;
    if (grant !== 16'h0 || timeout !== 1'b0 || grant_idx !== 4'd0) begin
      errors++; $display("FAIL midrst_drop: grant=%h tmo=%b idx=%0d want 0/0/0", grant, timeout, grant_idx);
    end
    rst = 1'b0; req = 16'h0081; tick();
    checks++;
    if (grant_idx !== 4'd0 || grant !== 16'h0001) begin
      errors++; $display("FAIL midrst_ptr0: idx=%0d grant=%h want 0/0001", grant_idx, grant);
    end
    req = '0; tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 16'h0003;
    for (int c = 0; c < TMO; c++) begin
      tick();
      checks++;
      if (grant_idx !== 4'd0 || grant_valid !== 1'b1 || timeout !== 1'b0) begin
        errors++; $display("FAIL tmo_hold%0d: idx=%0d valid=%b tmo=%b want 0/1/0", c, grant_idx, grant_valid, timeout);
      end
    end
`ifdef ARB_TIMEOUT_EN
    tick();
    checks++;
    if (grant !== 16'h0 || timeout !== 1'b1) begin
      errors++; $display("FAIL tmo_pulse: grant=%h tmo=%b want 0000/1", grant, timeout);
    end
    tick();
    checks++;
    if (grant_idx !== 4'd1 || grant_valid !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_next: idx=%0d valid=%b tmo=%b want 1/1/0", grant_idx, grant_valid, timeout);
    end
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (grant_idx !== 4'd0 || grant_valid !== 1'b1 || timeout !== 1'b0) begin
        errors++; $display("FAIL notmo_hold%0d: idx=%0d valid=%b tmo=%b want 0/1/0", c, grant_idx, grant_valid, timeout);
      end
    end
`endif
    req = '0; tick(); tick();
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    req = 16'h0003;
    for (int c = 0; c < TMO; c++) tick();
    req = 16'h0002;  // owner drops exactly as the counter expires
    tick();
    checks++;
    if (grant !== 16'h0 || timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_edge_release: grant=%h tmo=%b want 0000/0", grant, timeout);
    end
    tick();
    checks++;
    if (grant_idx !== 4'd1 || timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_edge_next: idx=%0d tmo=%b want 1/0", grant_idx, timeout);
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_random();
    logic [15:0] eg;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      case ($urandom_range(0, 3))
        0: req = 16'($urandom);
        1: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: req = m_busy ? (req | (16'd1 << m_owner)) : req;
        default: req = req ^ (16'd1 << $urandom_range(0, 15));
      endcase
      tick();
      eg = m_busy ? (16'd1 << m_owner) : 16'h0;
      checks++;
      if (grant !== eg || grant_idx !== (m_busy ? 4'(m_owner) : 4'd0) ||
          grant_valid !== m_busy || timeout !== m_tmo) begin
        errors++;
        $display("FAIL rand%0d: grant=%h idx=%0d valid=%b tmo=%b want %h/%0d/%b/%b",
                 n, grant, grant_idx, grant_valid, timeout, eg, m_busy ? m_owner : 0, m_busy, m_tmo);
      end
      checks++;
      if ($countones(grant) > 1) begin
        errors++; $display("FAIL rand_onehot%0d: grant=%h", n, grant);
      end
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_tmo = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_mid_reset();
    test_timeout();
    test_timeout_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
